conv_layer_stream: RTL
======================

Name: conv_layer_stream

Overview:
- Streaming, multi-channel, multi-filter 1-D convolution layer. Next generation of the single-filter, one-shot conv layer.
- Slides a KERNEL_HEIGHT x CHANNELS window over an input frame of INPUT_LAYER_HEIGHT rows, with configurable stride.
- Computes NUM_FILTERS outputs per window position in parallel MACs, then applies bias, saturation and optional ReLU.
- Emits one filter vector per window position over a valid/yumi interface. Sits between the input sample stream (or a previous layer) and the next layer.

Parameters:
- INPUT_LAYER_HEIGHT, 8, rows per frame.
- KERNEL_HEIGHT, 3, window rows.
- CHANNELS, 2, words per row, interleaved ch0..chC-1 (2 for I/Q).
- NUM_FILTERS, 4, parallel output filters.
- STRIDE, 1, rows advanced between windows. (INPUT_LAYER_HEIGHT-KERNEL_HEIGHT)%STRIDE must be 0; elaboration $error otherwise.
- WORD_SIZE, 16, data, weight and bias width, signed.
- INT_BITS, 4, integer bits of the fixed-point format. FRAC = WORD_SIZE-INT_BITS.
- RELU, 1, 1 clamps negative results to 0.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- valid_i  in  1  input word valid.
- ready_o  out  1  block accepts an input word.
- data_i  in  WORD_SIZE  signed input word.
- weights_i  in  NUM_FILTERS*KERNEL_HEIGHT*CHANNELS*WORD_SIZE  static weights; tap t = row*CHANNELS+ch, row 0 is the oldest row.
- biases_i  in  NUM_FILTERS*WORD_SIZE  static biases.
- valid_o  out  1  data_o holds a result.
- yumi_i  in  1  consumer takes the result (legal only while valid_o=1).
- data_o  out  NUM_FILTERS*WORD_SIZE  filter results, filter f at [f].
- last_o  out  1  qualifies valid_o; marks the final window of the frame.

Behaviour:
- Clocking and reset: one clock, clk_i. reset_i is synchronous and active-high.
- Reset values: state=eFILL, ready_o=1, valid_o=0, last_o=0, data_o=0. Accumulators, window buffer, and word and window counters all cleared.
- Reset mid-operation discards the partial window and any held result. The next accepted word is row 0, ch0 of a new frame.
- Input handshake: a word is accepted when valid_i && ready_o. It shifts into a KH*C-word window buffer.
- ready_o is a function of state only. It is 1 in eFILL and eSKIP and 0 otherwise.
- States:
  - eFILL: accept KH*C words. On the handshake of the last word go to eCOMPUTE.
  - eCOMPUTE: KH*C cycles. Tap counter t=0..KH*C-1. Each cycle every filter does acc[f] += w[f][t]*win[t], all in parallel. After the last tap go to eBIAS.
  - eBIAS: 1 cycle. Compute res = sat(relu((acc + (bias<<FRAC)) >>> FRAC)). Register into data_o. Go to eDONE.
  - eDONE: valid_o=1 and data_o held stable until yumi_i. On yumi_i, clear the accumulators and increment the window counter.
    - If this was the last window: go to eFILL, reset counters, and start a new frame.
    - Otherwise: go to eSKIP.
  - eSKIP: accept STRIDE*C words, shifting out the oldest rows. On the last handshake go to eCOMPUTE.
- Latency: last word handshake at cycle n. eCOMPUTE runs n+1..n+KH*C, eBIAS at n+KH*C+1, valid_o=1 from n+KH*C+2.
- Outputs per frame: (INPUT_LAYER_HEIGHT-KERNEL_HEIGHT)/STRIDE+1. last_o=1 only with the final one.
- Arithmetic:
  - Products are full 2*WORD_SIZE bits.
  - Accumulator width is 2*WORD_SIZE+$clog2(KH*C)+1, so there is no internal overflow.
  - The shift is arithmetic, truncating toward -inf.
  - Saturation clamps to [-2^(W-1), 2^(W-1)-1].
  - ReLU applies after saturation and only when RELU=1.
- Boundaries:
  - valid_i while ready_o=0 is ignored. The upstream producer holds the word.
  - yumi_i with valid_o=0 is illegal. The bench asserts on it.
  - yumi_i in the same cycle valid_o rises is legal. The next state is eSKIP or eFILL on the following cycle.
  - Weight or bias changes are sampled only during eCOMPUTE and eBIAS. Changes elsewhere have no effect on the current result.

Test Plan (KH=3, C=2, H=5, NF=2, W=16, INT_BITS=4, Q4.12, 1.0=0x1000):
1. All weights 1.0, biases 0, 10 words of 0x0800 (0.5) -> 3 outputs, each filter 0x3000. last_o on the 3rd output only. valid_o exactly 8 cycles after each window-completing handshake.
2. Weights 1.0, inputs 0x7000 (7.0), RELU=0 -> 0x7FFF. Inputs 0x9000 (-7.0) -> 0x8000. With RELU=1, inputs -7.0 -> 0x0000.
3. Filter 0 weights [1,0,0,0,0,-1]*1.0, bias 0x0400, inputs ramp 0x1000*k (k=0..9) -> f0 = -5.0+0.25 = 0xB400 for every window (RELU=0).
4. STRIDE=2, H=7 (14 words) -> 3 outputs. Exactly 4 words accepted in each eSKIP. ready_o=0 from the window-completing handshake until yumi_i.
5. yumi_i held 0 for 20 cycles with valid_i=1 -> data_o stable, ready_o=0, no word consumed. Then a 1-cycle yumi_i -> ready_o=1 next cycle.
6. reset_i asserted in the 3rd eCOMPUTE cycle -> next cycle valid_o=0, ready_o=1. The following clean frame matches scenario 1 values.

Source files
------------

// File: rtl/conv_layer_stream.sv
`default_nettype none
//==============================================================================
// conv_layer_stream : streaming multi-channel, multi-filter 1-D conv layer
// Rev 1.0
//==============================================================================
module conv_layer_stream #(
  parameter int INPUT_LAYER_HEIGHT = 8,
  parameter int KERNEL_HEIGHT      = 3,
  parameter int CHANNELS           = 2,
  parameter int NUM_FILTERS        = 4,
  parameter int STRIDE             = 1,
  parameter int WORD_SIZE          = 16,
  parameter int INT_BITS           = 4,
  parameter int RELU               = 1
) (
  input  logic                                                   clk_i,
  input  logic                                                   reset_i,
  input  logic                                                   valid_i,
  output logic                                                   ready_o,
  input  logic [WORD_SIZE-1:0]                                   data_i,
  input  logic [NUM_FILTERS*KERNEL_HEIGHT*CHANNELS*WORD_SIZE-1:0] weights_i,
  input  logic [NUM_FILTERS*WORD_SIZE-1:0]                       biases_i,
  output logic                                                   valid_o,
  input  logic                                                   yumi_i,
  output logic [NUM_FILTERS*WORD_SIZE-1:0]                       data_o,
  output logic                                                   last_o
);

  localparam int TAPS       = KERNEL_HEIGHT * CHANNELS;
  localparam int SKIP_WORDS = STRIDE * CHANNELS;
  localparam int NUM_WIN    = (INPUT_LAYER_HEIGHT - KERNEL_HEIGHT) / STRIDE + 1;
  localparam int FRAC       = WORD_SIZE - INT_BITS;
  localparam int PROD_W     = 2 * WORD_SIZE;
  localparam int ACC_W      = PROD_W + $clog2(TAPS) + 1;
  localparam int MAX_WORDS  = (TAPS > SKIP_WORDS) ? TAPS : SKIP_WORDS;
  localparam int CNT_W      = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int TAP_W      = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int WIN_W      = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;

  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(TAPS - 1);
  localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'(SKIP_WORDS - 1);
  localparam logic [TAP_W-1:0] TAP_LAST  = TAP_W'(TAPS - 1);
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(NUM_WIN - 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WORD_SIZE+1){1'b0}}, {(WORD_SIZE-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WORD_SIZE+1){1'b1}}, {(WORD_SIZE-1){1'b0}}};

  localparam logic [2:0] ST_FILL    = 3'd0;
  localparam logic [2:0] ST_COMPUTE = 3'd1;
  localparam logic [2:0] ST_BIAS    = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_SKIP    = 3'd4;

  if ((INPUT_LAYER_HEIGHT - KERNEL_HEIGHT) % STRIDE != 0) begin : g_bad_stride
    $error("conv_layer_stream: (INPUT_LAYER_HEIGHT-KERNEL_HEIGHT) must be a multiple of STRIDE");
  end

  logic [2:0]                       r_state;
  logic [CNT_W-1:0]                 r_cnt;
  logic [TAP_W-1:0]                 r_tap;
  logic [WIN_W-1:0]                 r_win_cnt;
  logic signed [WORD_SIZE-1:0]      r_win [TAPS];
  logic signed [ACC_W-1:0]          r_acc [NUM_FILTERS];
  logic [NUM_FILTERS*WORD_SIZE-1:0] r_data;

  logic                             w_accept;
  logic signed [WORD_SIZE-1:0]      w_tap_data;
  logic signed [WORD_SIZE-1:0]      w_wgt      [NUM_FILTERS][TAPS];
  logic signed [PROD_W-1:0]         w_mul      [NUM_FILTERS];
  logic signed [ACC_W-1:0]          w_prod     [NUM_FILTERS];
  logic signed [ACC_W-1:0]          w_bias_ext [NUM_FILTERS];
  logic signed [ACC_W-1:0]          w_biased   [NUM_FILTERS];
  logic signed [ACC_W-1:0]          w_shift    [NUM_FILTERS];
  logic [WORD_SIZE-1:0]             w_sat      [NUM_FILTERS];
  logic [WORD_SIZE-1:0]             w_res      [NUM_FILTERS];

  assign ready_o    = (r_state == ST_FILL) || (r_state == ST_SKIP);
  assign valid_o    = (r_state == ST_DONE);
  assign last_o     = valid_o && (r_win_cnt == WIN_LAST);
  assign data_o     = r_data;
  assign w_accept   = valid_i && ready_o;
  assign w_tap_data = r_win[r_tap];

  // Weight vector is filter-major: filter f, tap t lives at word f*TAPS+t.
  for (genvar f = 0; f < NUM_FILTERS; f++) begin : g_filt
    for (genvar t = 0; t < TAPS; t++) begin : g_tap
      assign w_wgt[f][t] = weights_i[(f*TAPS+t)*WORD_SIZE +: WORD_SIZE];
    end
    assign w_mul[f]      = w_wgt[f][r_tap] * w_tap_data;
    assign w_prod[f]     = {{(ACC_W-PROD_W){w_mul[f][PROD_W-1]}}, w_mul[f]};
    assign w_bias_ext[f] = {{(ACC_W-WORD_SIZE){biases_i[f*WORD_SIZE+WORD_SIZE-1]}},
                            biases_i[f*WORD_SIZE +: WORD_SIZE]} <<< FRAC;
    assign w_biased[f]   = r_acc[f] + w_bias_ext[f];
    assign w_shift[f]    = w_biased[f] >>> FRAC;
    assign w_sat[f]      = (w_shift[f] > SAT_MAX) ? SAT_MAX[WORD_SIZE-1:0] :
                           (w_shift[f] < SAT_MIN) ? SAT_MIN[WORD_SIZE-1:0] :
                                                    w_shift[f][WORD_SIZE-1:0];
    assign w_res[f]      = ((RELU != 0) && w_sat[f][WORD_SIZE-1]) ? '0 : w_sat[f];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= ST_FILL;
      r_cnt     <= '0;
      r_tap     <= '0;
      r_win_cnt <= '0;
      r_data    <= '0;
      for (int i = 0; i < TAPS; i++) r_win[i] <= '0;
      for (int f = 0; f < NUM_FILTERS; f++) r_acc[f] <= '0;
    end else begin
      // Newest word enters at the top so tap 0 always holds the oldest row.
      if (w_accept) begin
        for (int i = 0; i < TAPS-1; i++) r_win[i] <= r_win[i+1];
        r_win[TAPS-1] <= data_i;
      end
      case (r_state)
        ST_FILL: begin
          if (w_accept) begin
            if (r_cnt == FILL_LAST) begin
              r_cnt   <= '0;
              r_state <= ST_COMPUTE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        ST_SKIP: begin
          if (w_accept) begin
            if (r_cnt == SKIP_LAST) begin
              r_cnt   <= '0;
              r_state <= ST_COMPUTE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        ST_COMPUTE: begin
          for (int f = 0; f < NUM_FILTERS; f++) r_acc[f] <= r_acc[f] + w_prod[f];
          if (r_tap == TAP_LAST) begin
            r_tap   <= '0;
            r_state <= ST_BIAS;
          end else begin
            r_tap <= r_tap + TAP_W'(1);
          end
        end
        ST_BIAS: begin
          for (int f = 0; f < NUM_FILTERS; f++) r_data[f*WORD_SIZE +: WORD_SIZE] <= w_res[f];
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (yumi_i) begin
            for (int f = 0; f < NUM_FILTERS; f++) r_acc[f] <= '0;
            if (r_win_cnt == WIN_LAST) begin
              r_win_cnt <= '0;
              r_state   <= ST_FILL;
            end else begin
              r_win_cnt <= r_win_cnt + WIN_W'(1);
              r_state   <= ST_SKIP;
            end
          end
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

endmodule
`default_nettype wire
